// File: rtl/mem_responder_pkg.sv
// Shared bus definitions for the memory responder: command encoding, widths and tag constants.
// Also provides the system-wide `SD delay macro as an empty define when not already set.
`ifndef SD
`define SD
`endif

package mem_responder_pkg;

   localparam int XLEN      = 32;
   localparam int MEM_TAG_W = 4;
   localparam int NUM_TAGS  = 15;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'b00,
      BUS_LOAD  = 2'b01,
      BUS_STORE = 2'b10
   } bus_command_t;

   typedef logic [MEM_TAG_W-1:0] mem_tag_t;

endpackage

// File: rtl/mem_responder_if.sv
// Processor/memory bus bundle: request fields from the processor side, tag and return data from memory.
interface mem_responder_if;
   import mem_responder_pkg::*;

   bus_command_t    proc2mem_command;
   logic [XLEN-1:0] proc2mem_addr;
   logic [63:0]     proc2mem_data;
   mem_tag_t        mem2proc_response;
   logic [63:0]     mem2proc_data;
   mem_tag_t        mem2proc_tag;

   modport master (
      output proc2mem_command, proc2mem_addr, proc2mem_data,
      input  mem2proc_response, mem2proc_data, mem2proc_tag
   );

   modport slave (
      input  proc2mem_command, proc2mem_addr, proc2mem_data,
      output mem2proc_response, mem2proc_data, mem2proc_tag
   );

endinterface

// File: rtl/mem_tag_allocator.sv
// Free pool of transaction tags 1..15; offers the lowest free tag and reclaims tags as loads retire.
module mem_tag_allocator
   import mem_responder_pkg::*;
(
   input  logic     clock,
   input  logic     reset,
   input  logic     alloc,
   input  mem_tag_t free_tag,
   output mem_tag_t lowest_tag,
   output logic     any_free
);

   logic [NUM_TAGS:1] free_mask;

   // A freed tag only becomes visible after this edge, so it can never be reissued in its own cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         free_mask <= '1;
      end else begin
         if (alloc)
            free_mask[lowest_tag] <= 1'b0;
         if (free_tag != '0)
            free_mask[free_tag] <= 1'b1;
      end
   end

   always_comb begin
      lowest_tag = '0;
      for (int t = NUM_TAGS; t >= 1; t--) begin
         if (free_mask[t])
            lowest_tag = mem_tag_t'(t);
      end
   end

   assign any_free = |free_mask;

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: tagged accept, backing store, fixed-latency load return pipeline.
// Define MEM_BOUNDS_CHECK_EN to reject requests whose word index is beyond MEM_WORDS instead of wrapping.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int LATENCY   = 4,
   parameter int MEM_WORDS = 8192
)(
   input  logic            clock,
   input  logic            reset,
   mem_responder_if.slave  bus,
   output logic [4:0]      outstanding_cnt
);

   localparam int ADDR_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   logic [63:0]       mem [MEM_WORDS];
   logic [XLEN-1:0]   word_idx;
   logic [ADDR_W-1:0] mem_idx;
   logic [63:0]       load_word;
   logic              in_bounds;
   logic              is_load;
   logic              is_store;
   logic              accept;
   logic              load_accept;
   logic              store_accept;
   logic              any_free;
   mem_tag_t          lowest_tag;
   mem_tag_t          free_tag;
   mem_tag_t          pipe_tag  [LATENCY];
   logic [63:0]       pipe_data [LATENCY];

   assign word_idx = bus.proc2mem_addr >> 3;
   assign mem_idx  = ADDR_W'(word_idx % XLEN'(MEM_WORDS));

`ifdef MEM_BOUNDS_CHECK_EN
   assign in_bounds = (word_idx < XLEN'(MEM_WORDS));
`else
   assign in_bounds = 1'b1;
`endif

   // Stores need a free tag too, so a full pool back-pressures every request type alike.
   assign is_load      = (bus.proc2mem_command == BUS_LOAD);
   assign is_store     = (bus.proc2mem_command == BUS_STORE);
   assign accept       = (is_load || is_store) && any_free && in_bounds && !reset;
   assign load_accept  = accept && is_load;
   assign store_accept = accept && is_store;

   assign bus.mem2proc_response = accept ? lowest_tag : '0;

   // The array carries no reset so its contents survive a mid-run reset.
   always_ff @(posedge clock) begin
      if (store_accept)
         mem[mem_idx] <= bus.proc2mem_data;
   end

   assign load_word = mem[mem_idx];

   // Data only advances behind a live tag, so the last stage naturally holds its value across bubbles.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe_tag[i]  <= '0;
            pipe_data[i] <= '0;
         end
      end else begin
         pipe_tag[0] <= load_accept ? lowest_tag : '0;
         if (load_accept)
            pipe_data[0] <= load_word;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_tag[i] <= pipe_tag[i-1];
            if (pipe_tag[i-1] != '0)
               pipe_data[i] <= pipe_data[i-1];
         end
      end
   end

   assign bus.mem2proc_tag  = pipe_tag[LATENCY-1];
   assign bus.mem2proc_data = pipe_data[LATENCY-1];
   assign free_tag          = pipe_tag[LATENCY-1];

   mem_tag_allocator u_tag_allocator (
      .clock      (clock),
      .reset      (reset),
      .alloc      (load_accept),
      .free_tag   (free_tag),
      .lowest_tag (lowest_tag),
      .any_free   (any_free)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         outstanding_cnt <= '0;
      else if (load_accept && free_tag == '0)
         outstanding_cnt <= outstanding_cnt + 5'd1;
      else if (!load_accept && free_tag != '0)
         outstanding_cnt <= outstanding_cnt - 5'd1;
   end

endmodule
